// File: rtl/spike_interval_decoder.sv
// spike_interval_decoder
// Recovers the cycle distance between consecutive spikes as a binary value:
// the inverse of an axon delay line. A two-state FSM (IDLE / TIMING) counts
// cycles since the last reference spike. Each following spike captures the
// count into a single-entry output register that has a valid/ready handshake.
// If no second spike arrives within MAX cycles, a one-cycle timeout pulse is
// raised. A capture that finds the output register full raises a one-cycle
// dropped pulse instead.

module spike_interval_decoder #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    output logic [WIDTH-1:0] interval_out,
    output logic             interval_valid,
    input  logic             interval_ready,
    output logic             timeout,
    output logic             dropped
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_TIMING = 1'b1
    } state_t;

    // Saturating increment: the interval counter must never wrap to zero.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // FSM and counter state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_capture;
    logic             w_timeout_evt;

    // Output register state
    logic [WIDTH-1:0] r_interval;
    logic [WIDTH-1:0] w_interval_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             r_dropped;
    logic             w_dropped_evt;

    // Next-state logic: reference capture, counting, spike capture and timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        if (!enable) begin
            // Disabled: drop any reference; the output side is left alone.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (spike_in) begin
                        // First spike is a reference only; no measurement.
                        w_state_nxt = ST_TIMING;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                ST_TIMING: begin
                    if (spike_in) begin
                        // A spike beats the timeout, even when cnt == MAX.
                        w_capture   = 1'b1;
                        w_state_nxt = ST_TIMING;
                        w_cnt_nxt   = CNT_ONE;
                    end else if (r_cnt == CNT_MAX) begin
                        w_timeout_evt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_TIMING;
                        w_cnt_nxt   = sat_inc(r_cnt);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output handshake: load on capture when there is room, otherwise flag a drop.
    always_comb begin
        w_interval_nxt = r_interval;
        w_valid_nxt    = r_valid;
        w_dropped_evt  = 1'b0;
        if (w_capture) begin
            if (r_valid && !interval_ready) begin
                // Full and not being consumed: keep the held value stable.
                w_dropped_evt = 1'b1;
            end else begin
                w_interval_nxt = r_cnt;
                w_valid_nxt    = 1'b1;
            end
        end else if (r_valid && interval_ready) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // State, counter and registered outputs, with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_interval <= CNT_ZERO;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_interval <= w_interval_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_evt;
            r_dropped  <= w_dropped_evt;
        end
    end

    assign interval_out   = r_interval;
    assign interval_valid = r_valid;
    assign timeout        = r_timeout;
    assign dropped        = r_dropped;

endmodule

// File: doc/spike_interval_decoder.md
SPIKE_INTERVAL_DECODER -- requirements
Module: spike_interval_decoder

Interface
REQ-001 Parameter WIDTH, default 6, is the bit width of the interval counter and of interval_out; the maximum measurable interval is MAX = 2^WIDTH-1.
REQ-002 clock  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 enable  input  1  gates decoding: 1 = decode, 0 = hold the decoder idle.
REQ-005 spike_in  input  1  is a spike, level-sampled, where every cycle with spike_in=1 counts as one spike event.
REQ-006 interval_out  output  WIDTH  carries the measured spike-to-spike interval in clock cycles.
REQ-007 interval_valid  output  1  indicates that interval_out holds an unconsumed measurement.
REQ-008 interval_ready  input  1  indicates that the consumer accepts interval_out this cycle.
REQ-009 timeout  output  1  is a one-cycle pulse indicating that no second spike arrived within MAX cycles.
REQ-010 dropped  output  1  is a one-cycle pulse indicating that a measurement was discarded because the output register was full.

Function
REQ-011 The block SHALL implement the inverse of the axon delay line, recovering the cycle distance between consecutive spikes as a binary value.
REQ-012 The FSM SHALL have exactly two states, IDLE (no reference spike) and TIMING (counting from the last spike).
REQ-013 IDLE + enable + spike_in=1 SHALL set cnt <= 1 and state <= TIMING, with no measurement produced.
REQ-014 TIMING + enable + spike_in=0 + cnt<MAX SHALL increment cnt by 1.
REQ-015 TIMING + enable + spike_in=1 SHALL capture cnt as the measurement, set cnt <= 1 and remain in TIMING, so that a spike at cycle t1 following a spike at t0 yields interval t1-t0 (range 1..MAX).
REQ-016 TIMING + enable + spike_in=0 + cnt==MAX SHALL assert timeout for exactly the next cycle, clear cnt to 0, and enter IDLE.
REQ-017 A spike arriving when cnt==MAX SHALL take priority over timeout, be captured as interval MAX, and produce no timeout.
REQ-018 spike_in held high continuously SHALL yield one capture of interval 1 per cycle after the first high cycle.
REQ-019 The counter SHALL never wrap, and interval 0 SHALL never be produced.
REQ-020 enable=0 SHALL force state <= IDLE and cnt <= 0, suppress captures and timeout, and leave interval_out, interval_valid and handshaking unaffected.
REQ-021 A capture SHALL load interval_out and set interval_valid on the same edge (latency 1 cycle from the spike cycle) when interval_valid=0 or interval_ready=1 in that cycle.
REQ-022 A capture with interval_valid=1 and interval_ready=0 SHALL be discarded, assert dropped for exactly the next cycle, and leave interval_out unchanged.
REQ-023 interval_valid=1 with interval_ready=1 and no capture SHALL clear interval_valid on the next edge.
REQ-024 interval_out SHALL be stable whenever interval_valid=1 and interval_ready=0.
REQ-025 timeout and dropped SHALL never both be asserted from the same cycle's event, and each SHALL be low except for its defined one-cycle pulse.

Reset
REQ-026 reset=1 SHALL set state=IDLE, cnt=0, interval_out=0, interval_valid=0, timeout=0 and dropped=0 at the next edge, overriding all other inputs.
REQ-027 A reset asserted mid-measurement SHALL discard the partial count and any pending output, with no dropped or timeout pulse.
REQ-028 After reset deasserts, the first spike SHALL be treated as a reference spike only.

Verification
REQ-029 With WIDTH=6 and ready=1, spikes at cycles 10 and 17 -> interval_out=7 with valid=1 during cycle 18 only.
REQ-030 With ready=1, spikes at cycles 5, 6, 7 -> interval_out=1 at cycles 7 and 8.
REQ-031 A single spike at cycle 0 with no further spikes -> cnt reaches 63 and timeout pulses once at cycle 64; a spike at 63 instead -> interval_out=63 and no timeout.
REQ-032 With ready=0, spikes at 0, 4 and 9 -> interval_out=4 is held, dropped pulses at cycle 10, and setting ready=1 at cycle 12 -> valid=0 at cycle 13.
REQ-033 Spike at 0, enable=0 at cycle 3, enable=1 at cycle 4, spike at 8 -> no output (reference only), and the next spike at 11 -> interval_out=3.
REQ-034 Spike at 0, reset at cycle 5, spike at 9 -> no output and all outputs 0 at cycle 6; the next spike at 12 -> interval_out=3.
